progmem_arbiter: RTL
====================

// Module: progmem_arbiter
// PURPOSE
// - Shares one single-port synchronous program memory between NUM_CORES CORE fetch ports.
// - Sits directly upstream of each CORE's fetch stage and feeds it instruction words.
// - Round-robin grant, at most one read per cycle. Response arrives exactly 1 cycle after grant.
// PARAMETERS
// - NUM_CORES    4             number of requesting cores, >=1
// - INST_W       `INST_W       instruction word width
// - INST_ADDR_W  `INST_ADDR_W  instruction address width
// - PTR_W        clog2(NUM_CORES), min 1   round-robin pointer width (localparam)
// PORTS
// - clk              in   1                      clock, rising edge
// - rst              in   1                      synchronous, active-high reset
// - en               in   1                      global enable, same as CORE en
// - core_req         in   NUM_CORES              per-core fetch request; held until granted
// - core_addr        in   NUM_CORES*INST_ADDR_W  per-core fetch address; core i at [i*INST_ADDR_W +: INST_ADDR_W]
// - core_gnt         out  NUM_CORES              one-hot or zero; request accepted this cycle
// - core_resp_valid  out  NUM_CORES              one-hot or zero; core_resp_data is for core i
// - core_resp_data   out  INST_W                 instruction word, shared by all cores
// - mem_en           out  1                      memory read strobe
// - mem_addr         out  INST_ADDR_W            memory read address
// - mem_data         in   INST_W                 read data, valid 1 cycle after mem_en
// BEHAVIOUR
// - State: rr_ptr[PTR_W-1:0] and resp_sel[NUM_CORES-1:0], both registered.
// - Reset (rst=1 at posedge) sets rr_ptr=0 and resp_sel=0.
// - While rst=1: core_gnt=0 and mem_en=0 combinationally. core_resp_valid=resp_sel=0 from the first post-reset cycle.
// - Grant is combinational in cycle T:
//   - Search starts at index rr_ptr and wraps modulo NUM_CORES.
//   - The first i with core_req[i]=1 gets core_gnt[i]=1.
//   - Grant requires en=1 and rst=0.
// - In the grant cycle: mem_en=1 and mem_addr=core_addr[i].
//   - With no grant: mem_en=0 and mem_addr=0.
// - At posedge ending T with a grant to i:
//   - rr_ptr <= (i==NUM_CORES-1) ? 0 : i+1. The explicit wrap is required; NUM_CORES need not be a power of two.
//   - resp_sel <= onehot(i).
// - Without a grant at that posedge: rr_ptr holds and resp_sel <= 0.
// - Cycle T+1: core_resp_valid = resp_sel and core_resp_data = mem_data (passthrough, no register).
//   - Latency from grant to valid is exactly 1 cycle.
//   - Back-to-back grants give 1 response per cycle.
// - Fairness: a continuously requesting core is granted within NUM_CORES cycles while en=1.
// - Core i sees core_gnt[i] at most once per cycle. Core i may drop core_req[i] the cycle after its grant.
// - en=0:
//   - No grant. rr_ptr holds.
//   - resp_sel still clears to 0 at the next posedge, so an in-flight response is delivered once, never replayed.
// - rst during an outstanding read: resp_sel clears and the response is discarded. The memory output is ignored.
// - Requester changing core_addr while req=1 and not granted: legal. The address sampled in the grant cycle is used.
// - NUM_CORES=1: degenerate. rr_ptr stays 0 and core_gnt[0]=core_req[0]&en&~rst.
// STRUCTURE
// - defines.vh (shared): INST_W, INST_ADDR_W, and new `PROGMEM_RD_LAT = 1, documented as the fixed latency.
// - Sub-module rr_pick:
//   - Inputs: req vector, start pointer.
//   - Outputs: one-hot grant, granted index, any flag.
//   - Purely combinational; parameterised by N.
// - Top module holds rr_ptr, resp_sel, the address mux and the next-pointer logic.
// TESTING
// 1. Reset
//    - Stimulus: rst=1 for 2 cycles with core_req=4'b1111.
//    - Required: core_gnt=0, mem_en=0, core_resp_valid=0 throughout.
//    - Then: first cycle after rst=0 grants core 0.
// 2. Single requester
//    - Stimulus: core_req=4'b0100, core_addr[2]=0x10, memory word 0x10 holds 0xDEADBEEF.
//    - Required: gnt=4'b0100, mem_addr=0x10.
//    - Next cycle: resp_valid=4'b0100, resp_data=0xDEADBEEF.
// 3. All request continuously for 8 cycles
//    - Required grant order: 0,1,2,3,0,1,2,3.
//    - Each resp_valid matches the previous cycle's gnt.
//    - resp_data equals mem[addr of that core].
// 4. Wrap/skip
//    - Stimulus: rr_ptr=3 (after granting core 2), core_req=4'b0011.
//    - Required: core 0 granted; next grant core 1.
// 5. en gating
//    - Stimulus: grant core 1 in cycle T, drop en=0 in T+1 for 3 cycles.
//    - Required: resp_valid=4'b0010 in T+1 only; no grants while en=0; rr_ptr=2 preserved.
//    - Then: core 2 is granted first after en=1 if it requests.
// 6. Reset mid-flight
//    - Stimulus: grant core 3 in cycle T, rst=1 at posedge ending T.
//    - Required: resp_valid=0 in T+1; rr_ptr=0.

Source files
------------

// File: rtl/progmem_arbiter_pkg.sv
// Shared definitions for the program memory arbiter.
// Fixed read latency and pointer sizing helper.
`ifndef PROGMEM_DEFINES
`define PROGMEM_DEFINES
`define INST_W 32
`define INST_ADDR_W 12
// Program memory read latency in cycles (fixed)
`define PROGMEM_RD_LAT 1
`endif

package progmem_arbiter_pkg;

  localparam int RD_LAT = `PROGMEM_RD_LAT;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/progmem_arbiter_rr_pick.sv
// Round-robin picker: first requester at or after start,
// wrapping modulo N (N need not be a power of two).
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] start,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  // Scan from start, wrapping, and take the first requester
  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(start) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        gnt[j] = 1'b1;
        idx    = PW'(j);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/progmem_arbiter.sv
// Shares one single-port program memory among core fetch ports.
// Round-robin grant; response one cycle after grant.
module progmem_arbiter
  import progmem_arbiter_pkg::*;
#(
  parameter int NUM_CORES   = 4,
  parameter int INST_W      = `INST_W,
  parameter int INST_ADDR_W = `INST_ADDR_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic [NUM_CORES-1:0]             core_req,
  input  logic [NUM_CORES*INST_ADDR_W-1:0] core_addr,
  output logic [NUM_CORES-1:0]             core_gnt,
  output logic [NUM_CORES-1:0]             core_resp_valid,
  output logic [INST_W-1:0]                core_resp_data,
  output logic                             mem_en,
  output logic [INST_ADDR_W-1:0]           mem_addr,
  input  logic [INST_W-1:0]                mem_data
);

  localparam int PTR_W = ptr_w(NUM_CORES);

  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     nxt_ptr;
  logic [NUM_CORES-1:0] resp_sel;
  logic [NUM_CORES-1:0] pick_gnt;
  logic [PTR_W-1:0]     pick_idx;
  logic                 pick_any;
  logic                 ok;

  rr_pick #(
    .N  (NUM_CORES),
    .PW (PTR_W)
  ) u_pick (
    .req   (core_req),
    .start (rr_ptr),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign ok       = en & ~rst;
  assign core_gnt = ok ? pick_gnt : '0;
  assign mem_en   = ok & pick_any;

  // Route the granted core's address to memory, zero when idle
  always_comb begin
    mem_addr = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (core_gnt[i])
        mem_addr = core_addr[i*INST_ADDR_W +: INST_ADDR_W];
    end
  end

  // Pointer moves past the granted core with explicit wrap
  always_comb begin
    if (pick_idx == PTR_W'(NUM_CORES - 1))
      nxt_ptr = '0;
    else
      nxt_ptr = pick_idx + PTR_W'(1);
  end

  // Fairness pointer and response steering registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      resp_sel <= '0;
    end else begin
      resp_sel <= core_gnt;
      if (mem_en)
        rr_ptr <= nxt_ptr;
    end
  end

  assign core_resp_valid = resp_sel;
  assign core_resp_data  = mem_data;

endmodule
